// File: rtl/gshare_branch_predictor_if.sv
// Decode/execute-facing signal bundle for the gshare branch predictor.
// The master side (decode/execute) drives lookups and resolutions; the predictor is the slave.
interface gshare_branch_predictor_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned HIST_BITS  = 8
);
  logic                  mode;
  logic                  lookup_valid;
  logic [PC_WIDTH-1:0]   lookup_pc;
  logic                  pred_valid;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_index;
  logic [HIST_BITS-1:0]  pred_history;
  logic                  update_valid;
  logic [INDEX_BITS-1:0] update_index;
  logic                  update_taken;
  logic                  update_mispredict;
  logic [HIST_BITS-1:0]  update_history;
  logic [HIST_BITS-1:0]  ghr;
  logic                  init_done;

  modport master (
    output mode, lookup_valid, lookup_pc,
    output update_valid, update_index, update_taken, update_mispredict, update_history,
    input  pred_valid, pred_taken, pred_index, pred_history, ghr, init_done
  );

  modport slave (
    input  mode, lookup_valid, lookup_pc,
    input  update_valid, update_index, update_taken, update_mispredict, update_history,
    output pred_valid, pred_taken, pred_index, pred_history, ghr, init_done
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Bimodal/gshare direction predictor: saturating-counter table with speculative global
// history, execute-stage training and history repair, and a post-reset table sweep.
module gshare_branch_predictor #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned HIST_BITS  = 8,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned PC_LSB     = 2
) (
  input logic                     clock,
  input logic                     reset,
  gshare_branch_predictor_if.slave bus
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(DEPTH - 1);
  localparam logic [CTR_BITS-1:0]   CTR_WNT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};

  typedef enum logic {INIT, READY} state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic                  sweep_we;

  logic [CTR_BITS-1:0]   table_q [DEPTH];
  logic [HIST_BITS-1:0]  ghr_q;
  logic                  pred_valid_q, pred_taken_q, init_done_q;
  logic [INDEX_BITS-1:0] pred_index_q;
  logic [HIST_BITS-1:0]  pred_history_q;

  logic [PC_WIDTH-1:0]   pc;
  logic [INDEX_BITS-1:0] pc_idx, lookup_idx;
  logic                  lookup_ok, train_ok, repair_ok, lookup_taken;
  logic [CTR_BITS-1:0]   train_ctr, train_next;

  assign pc           = bus.lookup_pc;
  assign pc_idx       = INDEX_BITS'(pc >> PC_LSB);
  assign lookup_idx   = bus.mode ? (pc_idx ^ INDEX_BITS'(ghr_q)) : pc_idx;
  assign lookup_ok    = bus.lookup_valid && (state_q == READY);
  assign train_ok     = bus.update_valid && (state_q == READY);
  assign repair_ok    = train_ok && bus.update_mispredict;
  assign lookup_taken = table_q[lookup_idx][CTR_BITS-1];
  assign train_ctr    = table_q[bus.update_index];

  always_comb begin
    train_next = train_ctr;
    if (bus.update_taken) begin
      if (train_ctr != CTR_MAX) train_next = train_ctr + CTR_BITS'(1);
    end else begin
      if (train_ctr != '0) train_next = train_ctr - CTR_BITS'(1);
    end
  end

  // Sweep FSM: one weakly-not-taken write per cycle until the last entry.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sweep_we = 1'b0;
    case (state_q)
      INIT: begin
        sweep_we = 1'b1;
        ptr_d    = ptr_q + INDEX_BITS'(1);
        if (ptr_q == LAST_IDX) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= (state_d == READY);
    end
  end

  // Counter table: the sweep and training never overlap since training waits for READY.
  always_ff @(posedge clock) begin
    if (!reset && sweep_we) begin
      table_q[ptr_q] <= CTR_WNT;
    end else if (!reset && train_ok) begin
      table_q[bus.update_index] <= train_next;
    end
  end

  // Prediction outputs and history; a repair overrides a same-cycle speculative shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_index_q   <= '0;
      pred_history_q <= '0;
      ghr_q          <= '0;
    end else begin
      pred_valid_q <= lookup_ok;
      if (lookup_ok) begin
        pred_taken_q   <= lookup_taken;
        pred_index_q   <= lookup_idx;
        pred_history_q <= ghr_q;
      end
      if (repair_ok) begin
        ghr_q <= HIST_BITS'({bus.update_history, bus.update_taken});
      end else if (lookup_ok) begin
        ghr_q <= HIST_BITS'({ghr_q, lookup_taken});
      end
    end
  end

  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_taken   = pred_taken_q;
  assign bus.pred_index   = pred_index_q;
  assign bus.pred_history = pred_history_q;
  assign bus.ghr          = ghr_q;
  assign bus.init_done    = init_done_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor with a 16-entry table and 4-bit history.
module tb_gshare_branch_predictor;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  gshare_branch_predictor_if #(.PC_WIDTH(32), .INDEX_BITS(4), .HIST_BITS(4)) bus ();

  gshare_branch_predictor #(
    .PC_WIDTH(32), .INDEX_BITS(4), .HIST_BITS(4), .CTR_BITS(2), .PC_LSB(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of lookup/update inputs, then return 1 time unit after the edge.
  task automatic drive_cycle(input logic lv, input logic [31:0] pc, input logic uv,
                             input logic [3:0] idx, input logic tk, input logic mis,
                             input logic [3:0] hist);
    bus.lookup_valid      = lv;
    bus.lookup_pc         = pc;
    bus.update_valid      = uv;
    bus.update_index      = idx;
    bus.update_taken      = tk;
    bus.update_mispredict = mis;
    bus.update_history    = hist;
    @(posedge clock);
    #1;
    bus.lookup_valid      = 1'b0;
    bus.update_valid      = 1'b0;
    bus.update_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_index, bus.pred_history} !== 10'd0) begin
      failures++;
      $display("FAIL reset_pred got=%0h exp=0",
               {bus.pred_valid, bus.pred_taken, bus.pred_index, bus.pred_history});
    end
    checks++;
    if ({bus.ghr, bus.init_done} !== 5'd0) begin
      failures++;
      $display("FAIL reset_ghr_done got=%0h exp=0", {bus.ghr, bus.init_done});
    end
    reset = 1'b0;
    // Partial sweep with an ignored lookup on cycle 5, then reset again at cycle 8.
    for (int c = 1; c <= 8; c++) begin
      drive_cycle(c == 5, 32'h44, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
      checks++;
      if (bus.init_done !== 1'b0) begin
        failures++;
        $display("FAIL sweep1_done c=%0d got=%b exp=0", c, bus.init_done);
      end
      if (c == 5) begin
        checks++;
        if (bus.pred_valid !== 1'b0 || bus.ghr !== 4'd0) begin
          failures++;
          $display("FAIL init_lookup got=%b/%0h exp=0/0", bus.pred_valid, bus.ghr);
        end
      end
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
      checks++;
      if (bus.init_done !== (c == 16)) begin
        failures++;
        $display("FAIL sweep2_done c=%0d got=%b exp=%b", c, bus.init_done, c == 16);
      end
    end
  endtask

  task automatic test_bimodal();
    bus.mode = 1'b0;
    drive_cycle(1'b1, 32'h44, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_index, bus.pred_history} !== {1'b1, 1'b0, 4'd1, 4'd0}) begin
      failures++;
      $display("FAIL bimodal_first got=%0h exp=%0h",
               {bus.pred_valid, bus.pred_taken, bus.pred_index, bus.pred_history}, {1'b1, 1'b0, 4'd1, 4'd0});
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0);
    drive_cycle(1'b1, 32'h44, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bus.pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL bimodal_trained got=%b exp=1", bus.pred_taken);
    end
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0);
    drive_cycle(1'b0, 32'h0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bus.pred_valid !== 1'b0 || bus.pred_taken !== 1'b1 || bus.pred_index !== 4'd1) begin
      failures++;
      $display("FAIL pred_hold got=%b/%b/%0h exp=0/1/1", bus.pred_valid, bus.pred_taken, bus.pred_index);
    end
    drive_cycle(1'b1, 32'h44, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bus.pred_taken !== 1'b1 || bus.pred_history !== 4'b0001) begin
      failures++;
      $display("FAIL bimodal_sat_high got=%b/%0h exp=1/1", bus.pred_taken, bus.pred_history);
    end
    checks++;
    if (bus.ghr !== 4'b0011) begin
      failures++;
      $display("FAIL bimodal_ghr got=%0h exp=3", bus.ghr);
    end
  endtask

  task automatic test_saturate_low();
    bus.mode = 1'b0;
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0);
    drive_cycle(1'b1, 32'hC, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bus.pred_taken !== 1'b0 || bus.pred_index !== 4'd3) begin
      failures++;
      $display("FAIL sat_low got=%b/%0h exp=0/3", bus.pred_taken, bus.pred_index);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0);
    drive_cycle(1'b1, 32'hC, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL sat_low_plus1 got=%b exp=0", bus.pred_taken);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0);
    drive_cycle(1'b1, 32'hC, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bus.pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL sat_low_plus2 got=%b exp=1", bus.pred_taken);
    end
  endtask

  task automatic test_gshare();
    drive_cycle(1'b0, 32'h0, 1'b1, 4'd15, 1'b1, 1'b1, 4'b0010);
    checks++;
    if (bus.ghr !== 4'b0101) begin
      failures++;
      $display("FAIL gshare_force got=%0h exp=5", bus.ghr);
    end
    bus.mode = 1'b1;
    drive_cycle(1'b1, 32'h44, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_index, bus.pred_history} !== {1'b1, 1'b0, 4'b0100, 4'b0101}) begin
      failures++;
      $display("FAIL gshare_lookup got=%0h exp=%0h",
               {bus.pred_valid, bus.pred_taken, bus.pred_index, bus.pred_history}, {1'b1, 1'b0, 4'b0100, 4'b0101});
    end
    checks++;
    if (bus.ghr !== 4'b1010) begin
      failures++;
      $display("FAIL gshare_shift got=%0h exp=a", bus.ghr);
    end
    bus.mode = 1'b0;
    drive_cycle(1'b1, 32'h44, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({bus.pred_taken, bus.pred_index, bus.pred_history, bus.ghr} !== {1'b1, 4'd1, 4'b1010, 4'b0101}) begin
      failures++;
      $display("FAIL mode_switch got=%0h exp=%0h",
               {bus.pred_taken, bus.pred_index, bus.pred_history, bus.ghr}, {1'b1, 4'd1, 4'b1010, 4'b0101});
    end
  endtask

  task automatic test_repair_priority();
    drive_cycle(1'b0, 32'h0, 1'b1, 4'd15, 1'b1, 1'b1, 4'b0000);
    bus.mode = 1'b1;
    drive_cycle(1'b1, 32'h44, 1'b1, 4'd14, 1'b0, 1'b1, 4'b0011);
    checks++;
    if (bus.ghr !== 4'b0110) begin
      failures++;
      $display("FAIL repair_ghr got=%0h exp=6", bus.ghr);
    end
    checks++;
    if ({bus.pred_valid, bus.pred_index, bus.pred_history} !== {1'b1, 4'd0, 4'b0001}) begin
      failures++;
      $display("FAIL repair_pred got=%0h exp=%0h",
               {bus.pred_valid, bus.pred_index, bus.pred_history}, {1'b1, 4'd0, 4'b0001});
    end
    bus.update_valid      = 1'b0;
    bus.update_mispredict = 1'b1;
    bus.update_history    = 4'b1111;
    bus.update_taken      = 1'b1;
    @(posedge clock);
    #1;
    bus.update_mispredict = 1'b0;
    checks++;
    if (bus.ghr !== 4'b0110) begin
      failures++;
      $display("FAIL mispredict_no_valid got=%0h exp=6", bus.ghr);
    end
  endtask

  task automatic test_back_to_back();
    bus.mode = 1'b0;
    drive_cycle(1'b1, 32'h8, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0);
    checks++;
    if (bus.pred_taken !== 1'b0 || bus.pred_index !== 4'd2) begin
      failures++;
      $display("FAIL same_idx_nobypass got=%b/%0h exp=0/2", bus.pred_taken, bus.pred_index);
    end
    drive_cycle(1'b1, 32'h8, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL same_idx_after got=%b/%b exp=1/1", bus.pred_valid, bus.pred_taken);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.mode              = 1'b0;
    bus.lookup_valid      = 1'b0;
    bus.lookup_pc         = '0;
    bus.update_valid      = 1'b0;
    bus.update_index      = '0;
    bus.update_taken      = 1'b0;
    bus.update_mispredict = 1'b0;
    bus.update_history    = '0;
    test_reset();
    test_bimodal();
    test_saturate_low();
    test_gshare();
    test_repair_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
